axon_scan: RTL and testbench

- Initiator side of the axon→SD synaptic-accumulate interface.
- Accepts spike events (input-map coordinate plus lane bits) through a valid/ready handshake and buffers them in a small FIFO.
- Expands each spike over a KxK convolution window into a stream of single-cycle (vm address, weight address) pulses on the axon_sd_* bus.
- Inserts one idle cycle between spikes so the SD read-modify-write never sees the same Vm address back-to-back.

---
 rtl/axon_scan_if.sv | 31 +++
 rtl/axon_scan.sv | 157 +++++++++++++++
 tb/tb_axon_scan.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axon_scan_if.sv
// Spike-input handshake plus the axon->SD access bus driven by axon_scan.
// The slave view belongs to the scanner; the master view belongs to whatever feeds it.
interface axon_scan_if #(
  parameter int NNW     = 12,
  parameter int WD      = 6,
  parameter int CW      = 6,
  parameter int LAN_num = 2
);
  logic               spk_vld;
  logic               spk_rdy;
  logic [CW-1:0]      spk_x;
  logic [CW-1:0]      spk_y;
  logic [LAN_num-1:0] spk_lans;

  logic [NNW-1:0]     axon_sd_vm_addr;
  logic [WD-1:0]      axon_sd_wgt_addr;
  logic [LAN_num-1:0] axon_sd_lans;
  logic               axon_sd_vld;

  modport master (
    output spk_vld, spk_x, spk_y, spk_lans,
    input  spk_rdy,
    input  axon_sd_vm_addr, axon_sd_wgt_addr, axon_sd_lans, axon_sd_vld
  );

  modport slave (
    input  spk_vld, spk_x, spk_y, spk_lans,
    output spk_rdy,
    output axon_sd_vm_addr, axon_sd_wgt_addr, axon_sd_lans, axon_sd_vld
  );
endinterface

// File: rtl/axon_scan.sv
// Axon-side initiator: queues spike events and expands each one over a KxK window
// into single-cycle (Vm address, weight address) strobes toward the SD array.
module axon_scan #(
  parameter int NNW     = 12,
  parameter int WD      = 6,
  parameter int KW      = 3,
  parameter int CW      = 6,
  parameter int LAN_num = 2,
  parameter int FD      = 4
) (
  input  logic          clk_SD,
  input  logic          rst_n,
  axon_scan_if.slave    bus,
  input  logic [CW:0]   cfg_out_w,
  input  logic [CW:0]   cfg_out_h,
  input  logic [KW:0]   cfg_k,
  input  logic          axon_en,
  output logic          axon_busy
);
  localparam int AW = $clog2(FD);
  localparam int EW = 2 * CW + LAN_num;
  localparam logic [KW:0] K_MAX = (KW + 1)'(1 << KW);

  typedef enum logic [1:0] {IDLE, SCAN, GAP} state_t;

  state_t             state, next_state;
  logic [EW-1:0]      mem [FD];
  logic [EW-1:0]      head;
  logic [AW:0]        wr_ptr, rd_ptr;
  logic               full, empty, push, pop, step, last;
  logic [CW-1:0]      cur_x, cur_y;
  logic [LAN_num-1:0] cur_lans;
  logic [KW-1:0]      i_idx, j_idx, k_last;
  logic [KW:0]        k_eff, k_m1;
  logic signed [CW+1:0] ox, oy;
  logic               in_bounds;
  logic [NNW-1:0]     vm_calc;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign bus.spk_rdy = rst_n & ~full;
  assign push  = bus.spk_vld & rst_n & ~full;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_comb begin
    k_eff = cfg_k;
    if (cfg_k == '0)
      k_eff = (KW + 1)'(1);
    else if (cfg_k > K_MAX)
      k_eff = K_MAX;
  end

  assign k_m1   = k_eff - 1'b1;
  assign k_last = k_m1[KW-1:0];
  assign last   = (i_idx == k_last) && (j_idx == k_last);

  // Output-map coordinate hit by kernel tap (i,j); negative means off the map.
  assign ox = $signed({2'b00, cur_x}) - $signed({{(CW + 2 - KW){1'b0}}, j_idx});
  assign oy = $signed({2'b00, cur_y}) - $signed({{(CW + 2 - KW){1'b0}}, i_idx});
  assign in_bounds = ~ox[CW+1] && ~oy[CW+1] &&
                     (ox[CW:0] < cfg_out_w) && (oy[CW:0] < cfg_out_h);
  assign vm_calc = NNW'(oy[CW:0]) * NNW'(cfg_out_w) + NNW'(ox[CW:0]);

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = SCAN;
        end
      end
      SCAN: begin
        if (axon_en) begin
          step = 1'b1;
          if (last)
            next_state = GAP;
        end
      end
      GAP: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = SCAN;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_SD) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {bus.spk_x, bus.spk_y, bus.spk_lans};
  end

  always_ff @(posedge clk_SD) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_SD) begin
    if (!rst_n) begin
      state    <= IDLE;
      i_idx    <= '0;
      j_idx    <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      cur_lans <= '0;
    end else begin
      state <= next_state;
      if (pop) begin
        cur_x    <= head[EW-1 -: CW];
        cur_y    <= head[EW-CW-1 -: CW];
        cur_lans <= head[LAN_num-1:0];
        i_idx    <= '0;
        j_idx    <= '0;
      end else if (step) begin
        if (j_idx == k_last) begin
          j_idx <= '0;
          i_idx <= i_idx + 1'b1;
        end else begin
          j_idx <= j_idx + 1'b1;
        end
      end
    end
  end

  // Address and lane registers only move on a real strobe so the bus stays quiet otherwise.
  always_ff @(posedge clk_SD) begin
    if (!rst_n) begin
      bus.axon_sd_vld      <= 1'b0;
      bus.axon_sd_vm_addr  <= '0;
      bus.axon_sd_wgt_addr <= '0;
      bus.axon_sd_lans     <= '0;
    end else begin
      bus.axon_sd_vld <= step & in_bounds;
      if (step && in_bounds) begin
        bus.axon_sd_vm_addr  <= vm_calc;
        bus.axon_sd_wgt_addr <= {i_idx, j_idx};
        bus.axon_sd_lans     <= cur_lans;
      end
    end
  end

  assign axon_busy = (state != IDLE) | ~empty | bus.axon_sd_vld;

endmodule

// File: tb/tb_axon_scan.sv
// Self-checking bench for axon_scan: directed scenarios plus randomized spikes,
// all compared against a window-expansion model computed from the scan rules.
module tb_axon_scan;
  localparam int NNW = 12, WD = 6, KW = 3, CW = 6, LAN_num = 2, FD = 4;

  logic          clk_SD = 1'b0;
  logic          rst_n  = 1'b0;
  logic [CW:0]   cfg_out_w;
  logic [CW:0]   cfg_out_h;
  logic [KW:0]   cfg_k;
  logic          axon_en;
  logic          axon_busy;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int vld;
    int vm;
    int wgt;
    int lans;
  } slot_t;

  slot_t exp_slots[$];

  axon_scan_if #(.NNW(NNW), .WD(WD), .CW(CW), .LAN_num(LAN_num)) bus ();

  axon_scan #(.NNW(NNW), .WD(WD), .KW(KW), .CW(CW), .LAN_num(LAN_num), .FD(FD)) dut (
    .clk_SD    (clk_SD),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .cfg_out_w (cfg_out_w),
    .cfg_out_h (cfg_out_h),
    .cfg_k     (cfg_k),
    .axon_en   (axon_en),
    .axon_busy (axon_busy)
  );

  always #5 clk_SD = ~clk_SD;

  task automatic tick();
    @(posedge clk_SD);
    #1;
  endtask

  // Reference: every kernel tap of one spike in scan order, with its expected strobe.
  function automatic void build_slots(input int x, input int y, input int lans,
                                      input int w, input int h, input int k);
    int ke;
    ke = (k == 0) ? 1 : ((k > 8) ? 8 : k);
    exp_slots.delete();
    for (int i = 0; i < ke; i++) begin
      for (int j = 0; j < ke; j++) begin
        slot_t s;
        int ox;
        int oy;
        ox     = x - j;
        oy     = y - i;
        s.vld  = (ox >= 0 && ox < w && oy >= 0 && oy < h) ? 1 : 0;
        s.vm   = (oy * w + ox) % 4096;
        s.wgt  = i * 8 + j;
        s.lans = lans;
        exp_slots.push_back(s);
      end
    end
  endfunction

  task automatic set_cfg(input int w, input int h, input int k);
    cfg_out_w = (CW + 1)'(w);
    cfg_out_h = (CW + 1)'(h);
    cfg_k     = (KW + 1)'(k);
  endtask

  task automatic run_spike(input int x, input int y, input int lans,
                           input int w, input int h, input int k, input string name);
    int n;
    set_cfg(w, h, k);
    build_slots(x, y, lans, w, h, k);
    n = exp_slots.size();
    bus.spk_x    = CW'(x);
    bus.spk_y    = CW'(y);
    bus.spk_lans = LAN_num'(lans);
    bus.spk_vld  = 1'b1;
    vectors++;
    if (bus.spk_rdy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_rdy: got %b want 1", name, bus.spk_rdy);
    end
    tick();
    bus.spk_vld = 1'b0;
    tick();
    vectors++;
    if (bus.axon_sd_vld !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s_latency: vld got %b want 0", name, bus.axon_sd_vld);
    end
    for (int s = 0; s < n; s++) begin
      tick();
      vectors++;
      if (bus.axon_sd_vld !== 1'(exp_slots[s].vld)) begin
        miscompares++;
        $display("[TB] FAIL %s_vld[%0d]: got %b want %0d", name, s, bus.axon_sd_vld, exp_slots[s].vld);
      end else if (exp_slots[s].vld == 1) begin
        vectors++;
        if (bus.axon_sd_vm_addr !== NNW'(exp_slots[s].vm) ||
            bus.axon_sd_wgt_addr !== WD'(exp_slots[s].wgt) ||
            bus.axon_sd_lans !== LAN_num'(exp_slots[s].lans)) begin
          miscompares++;
          $display("[TB] FAIL %s_addr[%0d]: got vm=%0d wgt=%0d lans=%0d want vm=%0d wgt=%0d lans=%0d",
                   name, s, bus.axon_sd_vm_addr, bus.axon_sd_wgt_addr, bus.axon_sd_lans,
                   exp_slots[s].vm, exp_slots[s].wgt, exp_slots[s].lans);
        end
      end
    end
    vectors++;
    if (axon_busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_busy_gap: got %b want 1", name, axon_busy);
    end
    tick();
    vectors++;
    if (bus.axon_sd_vld !== 1'b0 || axon_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s_done: got vld=%b busy=%b want 0 0", name, bus.axon_sd_vld, axon_busy);
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.spk_vld = 1'b0;
    axon_en     = 1'b1;
    set_cfg(8, 8, 3);
    tick();
    tick();
    vectors++;
    if (bus.spk_rdy !== 1'b0 || bus.axon_sd_vld !== 1'b0 || axon_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got rdy=%b vld=%b busy=%b want 0 0 0",
               bus.spk_rdy, bus.axon_sd_vld, axon_busy);
    end
    vectors++;
    if (bus.axon_sd_vm_addr !== '0 || bus.axon_sd_wgt_addr !== '0 || bus.axon_sd_lans !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_bus: got vm=%0d wgt=%0d lans=%0d want 0 0 0",
               bus.axon_sd_vm_addr, bus.axon_sd_wgt_addr, bus.axon_sd_lans);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.spk_rdy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_release_rdy: got %b want 1", bus.spk_rdy);
    end
    tick();
  endtask

  task automatic test_single();
    run_spike(2, 2, int'($urandom_range(0, 3)), 8, 8, 3, "single");
  endtask

  task automatic test_corner();
    run_spike(0, 0, int'($urandom_range(0, 3)), 8, 8, 3, "corner");
  endtask

  task automatic test_boundary();
    run_spike(6, 3, int'($urandom_range(0, 3)), 5, 4, 3, "boundary");
  endtask

  task automatic test_pause();
    int s;
    int strobes;
    set_cfg(8, 8, 3);
    build_slots(2, 2, 2, 8, 8, 3);
    bus.spk_x = 6'd2; bus.spk_y = 6'd2; bus.spk_lans = 2'd2; bus.spk_vld = 1'b1;
    tick();
    bus.spk_vld = 1'b0;
    tick();
    s = 0;
    strobes = 0;
    for (int c = 0; c < 12; c++) begin
      axon_en = (c >= 4 && c <= 6) ? 1'b0 : 1'b1;
      tick();
      if (bus.axon_sd_vld === 1'b1) strobes++;
      vectors++;
      if (axon_en == 1'b0) begin
        if (bus.axon_sd_vld !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL pause_hold[%0d]: vld got %b want 0", c, bus.axon_sd_vld);
        end
      end else begin
        if (bus.axon_sd_vld !== 1'b1 || bus.axon_sd_vm_addr !== NNW'(exp_slots[s].vm) ||
            bus.axon_sd_wgt_addr !== WD'(exp_slots[s].wgt)) begin
          miscompares++;
          $display("[TB] FAIL pause_strobe[%0d]: got vld=%b vm=%0d wgt=%0d want 1 vm=%0d wgt=%0d",
                   c, bus.axon_sd_vld, bus.axon_sd_vm_addr, bus.axon_sd_wgt_addr,
                   exp_slots[s].vm, exp_slots[s].wgt);
        end
        s++;
      end
    end
    axon_en = 1'b1;
    tick();
    vectors++;
    if (strobes != 9 || axon_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL pause_total: got strobes=%0d busy=%b want 9 0", strobes, axon_busy);
    end
  endtask

  task automatic test_back_to_back();
    slot_t exp_all[$];
    slot_t obs[$];
    int    trace[$];
    int    pushed;
    int    saw_block;
    int    done;
    int    first;
    int    lastp;
    int    zeros;
    int    xs[6];
    int    ys[6];
    int    ls[6];
    logic  accept;
    set_cfg(8, 8, 2);
    for (int n = 0; n < 6; n++) begin
      xs[n] = 1 + n;
      ys[n] = 7 - n;
      ls[n] = int'($urandom_range(0, 3));
      build_slots(xs[n], ys[n], ls[n], 8, 8, 2);
      foreach (exp_slots[q]) exp_all.push_back(exp_slots[q]);
    end
    pushed = 0; saw_block = 0; done = 0;
    bus.spk_x = CW'(xs[0]); bus.spk_y = CW'(ys[0]); bus.spk_lans = LAN_num'(ls[0]);
    bus.spk_vld = 1'b1;
    for (int c = 0; c < 300 && done == 0; c++) begin
      accept = bus.spk_vld & bus.spk_rdy;
      if (bus.spk_vld === 1'b1 && bus.spk_rdy === 1'b0) saw_block = 1;
      tick();
      if (accept) begin
        pushed++;
        if (pushed < 6) begin
          bus.spk_x = CW'(xs[pushed]); bus.spk_y = CW'(ys[pushed]); bus.spk_lans = LAN_num'(ls[pushed]);
        end else begin
          bus.spk_vld = 1'b0;
        end
      end
      trace.push_back(bus.axon_sd_vld === 1'b1 ? 1 : 0);
      if (bus.axon_sd_vld === 1'b1) begin
        slot_t o;
        o.vld = 1; o.vm = int'(bus.axon_sd_vm_addr); o.wgt = int'(bus.axon_sd_wgt_addr);
        o.lans = int'(bus.axon_sd_lans);
        obs.push_back(o);
      end
      if (pushed == 6 && axon_busy === 1'b0) done = 1;
    end
    bus.spk_vld = 1'b0;
    vectors++;
    if (done == 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_timeout: pushed=%0d busy=%b want 6 0", pushed, axon_busy);
    end
    vectors++;
    if (saw_block == 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_rdy_drop: got never-low want low-when-full");
    end
    vectors++;
    if (obs.size() != exp_all.size()) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d strobes want %0d", obs.size(), exp_all.size());
    end
    for (int q = 0; q < obs.size() && q < exp_all.size(); q++) begin
      vectors++;
      if (obs[q].vm != exp_all[q].vm || obs[q].wgt != exp_all[q].wgt || obs[q].lans != exp_all[q].lans) begin
        miscompares++;
        $display("[TB] FAIL b2b_order[%0d]: got vm=%0d wgt=%0d lans=%0d want vm=%0d wgt=%0d lans=%0d",
                 q, obs[q].vm, obs[q].wgt, obs[q].lans, exp_all[q].vm, exp_all[q].wgt, exp_all[q].lans);
      end
    end
    first = -1; lastp = -1; zeros = 0;
    foreach (trace[q]) if (trace[q] == 1) begin
      if (first < 0) first = q;
      lastp = q;
    end
    for (int q = first; q >= 0 && q <= lastp; q++) if (trace[q] == 0) zeros++;
    vectors++;
    if (zeros != 5 || (lastp - first + 1) != 29) begin
      miscompares++;
      $display("[TB] FAIL b2b_gaps: got zeros=%0d span=%0d want 5 29", zeros, lastp - first + 1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      run_spike(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 64)),
                int'($urandom_range(1, 64)), int'($urandom_range(0, 15)), "random");
    end
  endtask

  task automatic test_reset_mid();
    int strobes;
    int after;
    set_cfg(8, 8, 3);
    strobes = 0;
    bus.spk_x = 6'd2; bus.spk_y = 6'd2; bus.spk_lans = 2'd1; bus.spk_vld = 1'b1;
    tick();
    bus.spk_x = 6'd5; bus.spk_y = 6'd5;
    tick();
    bus.spk_x = 6'd6; bus.spk_y = 6'd6;
    tick();
    bus.spk_vld = 1'b0;
    if (bus.axon_sd_vld === 1'b1) strobes++;
    for (int c = 0; c < 10 && strobes < 3; c++) begin
      tick();
      if (bus.axon_sd_vld === 1'b1) strobes++;
    end
    vectors++;
    if (strobes != 3 || axon_busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_pre: got strobes=%0d busy=%b want 3 1", strobes, axon_busy);
    end
    rst_n = 1'b0;
    tick();
    vectors++;
    if (bus.axon_sd_vld !== 1'b0 || axon_busy !== 1'b0 || bus.spk_rdy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_edge: got vld=%b busy=%b rdy=%b want 0 0 0",
               bus.axon_sd_vld, axon_busy, bus.spk_rdy);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.spk_rdy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_rdy: got %b want 1", bus.spk_rdy);
    end
    after = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.axon_sd_vld !== 1'b0 || axon_busy !== 1'b0) after++;
    end
    vectors++;
    if (after != 0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_quiet: got %0d active cycles want 0", after);
    end
  endtask

  initial begin
    bus.spk_vld  = 1'b0;
    bus.spk_x    = '0;
    bus.spk_y    = '0;
    bus.spk_lans = '0;
    axon_en      = 1'b1;
    test_reset();
    test_single();
    test_corner();
    test_boundary();
    test_pause();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
